// File: rtl/prime_pkg.sv
// Shared types and constants for the prime search controller.
// Imported by the controller and its bench.
package prime_pkg;

  localparam int WIDTH_DEF = 16;

  localparam logic [WIDTH_DEF-1:0] MAX_W =
    {WIDTH_DEF{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

endpackage

// File: rtl/prime_search_modulo.sv
// Bit-serial remainder unit: a go rising edge latches a and b,
// one quotient bit per cycle, ready returns with res = a % b.
module modulo #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             error,
  output logic [WIDTH-1:0] res
);

  localparam int CW = $clog2(WIDTH + 1);

  logic             busy_q, busy_d;
  logic             go_prev_q;
  logic             error_q, error_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= 1'b0;
      go_prev_q <= 1'b0;
      error_q   <= 1'b0;
      res_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
    end else begin
      busy_q    <= busy_d;
      go_prev_q <= go;
      error_q   <= error_d;
      res_q     <= res_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    busy_d  = busy_q;
    error_d = error_q;
    res_d   = res_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    rem_sh  = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    if (busy_q) begin
      // rem stays below the divisor, so WIDTH+1 bits never overflow
      if (rem_sh >= {1'b0, dvs_q})
        rem_sh = rem_sh - {1'b0, dvs_q};
      rem_d = rem_sh;
      dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        res_d  = rem_sh[WIDTH-1:0];
      end
    end else if (go && !go_prev_q) begin
      error_d = (b == '0);
      busy_d  = (b != '0);
      dvd_d   = a;
      dvs_d   = b;
      rem_d   = '0;
      cnt_d   = CW'(WIDTH);
    end
  end

  assign ready = !busy_q;
  assign error = error_q;
  assign res   = res_q;

endmodule

// File: rtl/prime_search.sv
// Smallest prime strictly above start, by trial division
// through one shared modulo unit.
module prime_search
  import prime_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [WIDTH-1:0] start,
  output logic             ready,
  output logic             error,
  output logic [WIDTH-1:0] res
);

  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] TWO  = WIDTH'(2);

  state_e           state_q, state_d;
  logic             go_prev_q;
  logic             ready_q, ready_d;
  logic             error_q, error_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] div_q, div_d;

  logic             go_edge;
  logic [2*WIDTH-1:0] div_sq;

  logic             mod_go;
  logic [WIDTH-1:0] mod_a, mod_b;
  logic             mod_ready, mod_error;
  logic [WIDTH-1:0] mod_res;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      go_prev_q <= 1'b0;
      ready_q   <= 1'b1;
      error_q   <= 1'b0;
      res_q     <= '0;
      cand_q    <= '0;
      div_q     <= '0;
    end else begin
      state_q   <= state_d;
      go_prev_q <= go;
      ready_q   <= ready_d;
      error_q   <= error_d;
      res_q     <= res_d;
      cand_q    <= cand_d;
      div_q     <= div_d;
    end
  end

  assign go_edge = go && !go_prev_q;
  assign div_sq  = (2*WIDTH)'(div_q) * (2*WIDTH)'(div_q);

  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    error_d = error_q;
    res_d   = res_q;
    cand_d  = cand_q;
    div_d   = div_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (go_edge) begin
          if (start == ONES) begin
            error_d = 1'b1;
            ready_d = 1'b1;
            state_d = S_DONE;
          end else begin
            cand_d  = (start == '0) ? TWO : start + 1'b1;
            div_d   = TWO;
            ready_d = 1'b0;
            error_d = 1'b0;
            state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (div_sq > (2*WIDTH)'(cand_q)) begin
          res_d   = cand_q;
          ready_d = 1'b1;
          error_d = 1'b0;
          state_d = S_DONE;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (mod_ready) begin
          state_d = S_CHECK;
          if (mod_res == '0) begin
            if (cand_q == ONES) begin
              error_d = 1'b1;
              ready_d = 1'b1;
              state_d = S_DONE;
            end else begin
              cand_d = cand_q + 1'b1;
              div_d  = TWO;
            end
          end else begin
            div_d = (div_q == TWO) ? WIDTH'(3)
                                   : div_q + WIDTH'(2);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mod_go = (state_q == S_ISSUE);
    mod_a  = cand_q;
    mod_b  = div_q;
  end

  modulo #(.WIDTH(WIDTH)) u_mod (
    .clk   (clk),
    .rst   (rst),
    .go    (mod_go),
    .a     (mod_a),
    .b     (mod_b),
    .ready (mod_ready),
    .error (mod_error),
    .res   (mod_res)
  );

  assign ready = ready_q;
  assign error = error_q;
  assign res   = res_q;

  // divisor is always >= 2, so a divide-by-zero means corrupt state
  a_no_mod_err: assert property (
    @(posedge clk) disable iff (rst) !(mod_ready && mod_error));

endmodule

// File: tb/tb_prime_search.sv
// Randomized and directed bench for prime_search against a
// plain-arithmetic next-prime model.
module tb_prime_search;
  import prime_pkg::*;

  localparam int W    = WIDTH_DEF;
  localparam int MAXV = int'(MAX_W);

  logic         clk = 1'b0;
  logic         rst;
  logic         go;
  logic [W-1:0] start;
  logic         ready;
  logic         error;
  logic [W-1:0] res;

  int n_chk  = 0;
  int n_pass = 0;
  int last_res = 0;

  longint issued[$];
  longint exp_iss[$];

  prime_search #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .go    (go),
    .start (start),
    .ready (ready),
    .error (error),
    .res   (res)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (dut.mod_go)
      issued.push_back(longint'({dut.mod_a, dut.mod_b}));

  task automatic check(input string tag,
                       input longint obs,
                       input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
  endtask

  function automatic bit is_prime(int n);
    if (n < 2) return 1'b0;
    for (int d = 2; d * d <= n; d++)
      if (n % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int next_prime(int s);
    for (int n = s + 1; n <= MAXV; n++)
      if (is_prime(n)) return n;
    return -1;
  endfunction

  // Trial order: 2, then odd divisors, stop at d*d > n or a hit
  function automatic void plan(int s);
    exp_iss.delete();
    for (int n = (s + 1 < 2) ? 2 : s + 1; n <= MAXV; n++) begin
      bit comp = 1'b0;
      for (int d = 2; d * d <= n && !comp;
           d = (d == 2) ? 3 : d + 2) begin
        exp_iss.push_back(longint'(n) * 65536 + d);
        if (n % d == 0) comp = 1'b1;
      end
      if (!comp) return;
    end
  endfunction

  task automatic wait_ready(input int budget);
    int n = 0;
    while (!ready && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("ready_in_time", ready, 1);
  endtask

  task automatic check_result(input int s);
    int p = next_prime(s);
    if (p < 0) begin
      check("error_set", error, 1);
      check("res_kept", res, last_res);
    end else begin
      check("error_clr", error, 0);
      check("res", res, p);
      last_res = p;
    end
  endtask

  task automatic search(input int s);
    plan(s);
    @(negedge clk);
    issued.delete();
    go    = 1'b1;
    start = W'(s);
    @(negedge clk);
    go = 1'b0;
    if (s != MAXV) check("busy_after_go", ready, 0);
    wait_ready(exp_iss.size() * 30 + 40);
    check_result(s);
    check("issue_count", issued.size(), exp_iss.size());
  endtask

  initial begin
    int s;
    int falls;
    bit prev_rdy;
    int n;

    rst   = 1'b1;
    go    = 1'b0;
    start = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_error", error, 0);
    check("rst_res", res, 0);
    rst = 1'b0;

    search(0);
    search(1);
    search(13);
    for (int i = 0; i < exp_iss.size(); i++)
      if (i < issued.size())
        check($sformatf("iss13_%0d", i), issued[i], exp_iss[i]);
    search(24);
    search(2);
    search(65520);
    search(65521);
    search(65535);

    // go held high: one search only
    @(negedge clk);
    go    = 1'b1;
    start = W'(100);
    falls = 0;
    prev_rdy = ready;
    repeat (500) begin
      @(negedge clk);
      if (prev_rdy && !ready) falls++;
      prev_rdy = ready;
    end
    go = 1'b0;
    check("hold_one_search", falls, 1);
    check("hold_res", res, 101);
    last_res = 101;

    // go pulse during WAIT is ignored
    @(negedge clk);
    issued.delete();
    go    = 1'b1;
    start = W'(200);
    @(negedge clk);
    go = 1'b0;
    n = 0;
    while (issued.size() < 1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    go    = 1'b1;
    start = W'(5);
    @(negedge clk);
    go = 1'b0;
    wait_ready(2000);
    check("pulse_ignored", res, 211);
    last_res = 211;

    // reset during the third WAIT
    @(negedge clk);
    issued.delete();
    go    = 1'b1;
    start = W'(1000);
    @(negedge clk);
    go = 1'b0;
    n = 0;
    while (issued.size() < 3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("third_issue_seen", issued.size(), 3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ready", ready, 1);
    check("midrst_error", error, 0);
    check("midrst_res", res, 0);
    last_res = 0;
    search(1000);

    for (int i = 0; i < 24; i++) begin
      if (i % 6 == 5) s = int'($urandom_range(65400, 65535));
      else            s = int'($urandom_range(0, 3000));
      search(s);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
